// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg
//   Shared definitions for the SPI configuration controller: frame state
//   encoding, header field positions, the ID opcode and the register count.
//   Imported by spi_cfg_bank and spi_cfg_ctrl.
package spi_cfg_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_DONE
   } state_t;

   localparam int unsigned NUM_REGS = 4;

   // Header byte layout
   localparam int unsigned HDR_WR_BIT  = 7;
   localparam int unsigned HDR_INC_BIT = 6;
   localparam int unsigned HDR_REG_LSB = 4;
   localparam int unsigned HDR_LEN_LSB = 0;

   localparam logic [7:0] ID_OPCODE = 8'h8F;

   typedef logic [$clog2(NUM_REGS)-1:0] reg_addr_t;

   // Register pointer step; 2-bit arithmetic gives the 3 -> 0 wrap.
   function automatic reg_addr_t next_addr(input reg_addr_t a, input logic inc);
      return inc ? reg_addr_t'(a + reg_addr_t'(1)) : a;
   endfunction

endpackage

// File: rtl/spi_cfg_ctrl_if.sv
// spi_cfg_ctrl_if
//   Byte-level handshake between the SPI shifter and the frame controller.
//   Signals:
//     ss       - slave select, active-low (high = frame boundary)
//     rx_valid - one-cycle strobe, rx_byte holds a complete byte
//     rx_byte  - received byte
//     tx_load  - one-cycle strobe, shifter loads tx_byte
//     tx_byte  - next byte to shift out
//   Modports: master = shifter side, slave = controller side.
interface spi_cfg_ctrl_if;
   logic       ss;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic       tx_load;
   logic [7:0] tx_byte;

   modport master (
      output ss, rx_valid, rx_byte,
      input  tx_load, tx_byte
   );

   modport slave (
      input  ss, rx_valid, rx_byte,
      output tx_load, tx_byte
   );
endinterface

// File: rtl/spi_cfg_bank.sv
// spi_cfg_bank
//   4x8 configuration register file with write port, combinational read mux
//   of the committed bank, and commit strobe.
//   Build option: SPI_CFG_SHADOW_EN - writes land in a shadow bank that is
//   copied to cfg on commit; discard reloads the shadow from cfg.
//   Ports:
//     sclk, rst_n  - clock, synchronous active-low reset
//     we/waddr/wdata - byte write
//     commit       - last write of a complete frame (shadow build)
//     discard      - no write frame active, drop shadow contents (shadow build)
//     raddr/rdata  - read of committed bank
//     cfg          - committed bank, byte n at [8n+7:8n]
//     update       - one-cycle pulse when cfg changed on the previous edge
module spi_cfg_bank
   import spi_cfg_pkg::*;
#(
   parameter logic [31:0] CFG_RESET = 32'h0000_0000
) (
   input  logic        sclk,
   input  logic        rst_n,
   input  logic        we,
   input  reg_addr_t   waddr,
   input  logic [7:0]  wdata,
   input  logic        commit,
   input  logic        discard,
   input  reg_addr_t   raddr,
   output logic [7:0]  rdata,
   output logic [31:0] cfg,
   output logic        update
);

   always_comb begin
      rdata = cfg[{raddr, 3'b000} +: 8];
   end

`ifdef SPI_CFG_SHADOW_EN
   logic [31:0] shadow;
   logic [31:0] shadow_next;

   // Merge the current write so the commit edge includes the final byte.
   always_comb begin
      shadow_next = shadow;
      if (we) shadow_next[{waddr, 3'b000} +: 8] = wdata;
   end

   always_ff @(posedge sclk) begin
      if (!rst_n) begin
         shadow <= CFG_RESET;
         cfg    <= CFG_RESET;
         update <= 1'b0;
      end else begin
         update <= commit;
         if (commit) cfg <= shadow_next;
         if (discard) shadow <= cfg;
         else         shadow <= shadow_next;
      end
   end
`else
   logic unused_ok;
   assign unused_ok = &{1'b0, commit, discard};

   always_ff @(posedge sclk) begin
      if (!rst_n) begin
         cfg    <= CFG_RESET;
         update <= 1'b0;
      end else begin
         update <= we;
         if (we) cfg[{waddr, 3'b000} +: 8] <= wdata;
      end
   end
`endif

endmodule

// File: rtl/spi_cfg_ctrl.sv
// spi_cfg_ctrl
//   Frame-level controller behind the byte-wide SPI shifter. Parses header +
//   payload frames, writes/reads the 4-byte configuration bank and sequences
//   bytes returned to the shifter. Header: [7] write, [6] auto-increment,
//   [5:4] start register, [3:0] length-1. Header 8'h8F returns ID_BYTE.
//   Build option: SPI_CFG_SHADOW_EN - config_data updates only when a write
//   frame completes (see spi_cfg_bank).
//   Ports:
//     sclk, rst_n  - clock, synchronous active-low reset
//     bus          - shifter handshake (spi_cfg_ctrl_if.slave)
//     config_data  - committed configuration bank
//     cfg_update   - pulse on the cycle config_data shows a change
//     busy         - read/write frame in progress
//     frame_err    - bytes received past the end of the frame
module spi_cfg_ctrl
   import spi_cfg_pkg::*;
#(
   parameter logic [31:0] CFG_RESET = 32'h0000_0000,
   parameter logic [7:0]  ID_BYTE   = 8'hAA
) (
   input  logic          sclk,
   input  logic          rst_n,
   spi_cfg_ctrl_if.slave bus,
   output logic [31:0]   config_data,
   output logic          cfg_update,
   output logic          busy,
   output logic          frame_err
);

   state_t     state;
   reg_addr_t  addr;
   logic       inc;
   logic [3:0] remaining;
   logic       tx_load_q;
   logic [7:0] tx_byte_q;

   logic       hdr_wr;
   logic       hdr_inc;
   reg_addr_t  hdr_reg;
   logic [3:0] hdr_len;

   logic       bank_we;
   logic       bank_commit;
   logic       bank_discard;
   reg_addr_t  bank_raddr;
   logic [7:0] bank_rdata;

   assign bus.tx_load = tx_load_q;
   assign bus.tx_byte = tx_byte_q;

   always_comb begin
      hdr_wr  = bus.rx_byte[HDR_WR_BIT];
      hdr_inc = bus.rx_byte[HDR_INC_BIT];
      hdr_reg = bus.rx_byte[HDR_REG_LSB +: 2];
      hdr_len = bus.rx_byte[HDR_LEN_LSB +: 4];
   end

   // ss high masks rx_valid, so a byte arriving with ss is never written.
   always_comb begin
      bank_we      = bus.rx_valid && !bus.ss && (state == ST_WRITE);
      bank_commit  = bank_we && (remaining == 4'd0);
      bank_discard = (state != ST_WRITE);
      bank_raddr   = (state == ST_IDLE) ? hdr_reg : addr;
   end

   spi_cfg_bank #(
      .CFG_RESET (CFG_RESET)
   ) u_bank (
      .sclk    (sclk),
      .rst_n   (rst_n),
      .we      (bank_we),
      .waddr   (addr),
      .wdata   (bus.rx_byte),
      .commit  (bank_commit),
      .discard (bank_discard),
      .raddr   (bank_raddr),
      .rdata   (bank_rdata),
      .cfg     (config_data),
      .update  (cfg_update)
   );

   always_ff @(posedge sclk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         addr      <= '0;
         inc       <= 1'b0;
         remaining <= '0;
         tx_load_q <= 1'b0;
         tx_byte_q <= '0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         tx_load_q <= 1'b0;
         if (bus.ss) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            tx_byte_q <= '0;
         end else if (bus.rx_valid) begin
            case (state)
               ST_IDLE: begin
                  frame_err <= 1'b0;
                  if (bus.rx_byte == ID_OPCODE) begin
                     tx_byte_q <= ID_BYTE;
                     tx_load_q <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     inc       <= hdr_inc;
                     remaining <= hdr_len;
                     busy      <= 1'b1;
                     if (hdr_wr) begin
                        addr  <= hdr_reg;
                        state <= ST_WRITE;
                     end else begin
                        // First read byte is returned off the header itself.
                        addr      <= next_addr(hdr_reg, hdr_inc);
                        tx_byte_q <= bank_rdata;
                        tx_load_q <= 1'b1;
                        state     <= ST_READ;
                     end
                  end
               end
               ST_WRITE: begin
                  addr <= next_addr(addr, inc);
                  if (remaining == 4'd0) begin
                     state <= ST_DONE;
                     busy  <= 1'b0;
                  end else begin
                     remaining <= remaining - 4'd1;
                  end
               end
               ST_READ: begin
                  tx_load_q <= 1'b1;
                  if (remaining == 4'd0) begin
                     tx_byte_q <= '0;
                     state     <= ST_DONE;
                     busy      <= 1'b0;
                  end else begin
                     tx_byte_q <= bank_rdata;
                     addr      <= next_addr(addr, inc);
                     remaining <= remaining - 4'd1;
                  end
               end
               ST_DONE: begin
                  frame_err <= 1'b1;
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
